// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: builds S in an external RAM, then writes a length-prefixed ciphertext
// from a length-prefixed plaintext and flags any non-printable plaintext data byte.
module arc4_encrypt #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   bad_pt,
  output logic [7:0]             pt_addr,
  input  logic [7:0]             pt_rddata,
  output logic [7:0]             ct_addr,
  output logic [7:0]             ct_wrdata,
  output logic                   ct_wren,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren
);

  localparam int KIW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    IDLE, INIT,
    KSA_RI, KSA_GI, KSA_GJ, KSA_WJ,
    LEN_RD, LEN_GET,
    PRGA_RI, PRGA_GI, PRGA_GJ, PRGA_WJ, PRGA_RP, PRGA_GP,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0]             si_q, si_d, sj_q, sj_d, pt_q, pt_d;
  logic [KIW-1:0]         keyIdx_q, keyIdx_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic                   bad_q, bad_d;
  logic [7:0]             keyByte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      len_q    <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      pt_q     <= '0;
      keyIdx_q <= '0;
      key_q    <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      len_q    <= len_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      pt_q     <= pt_d;
      keyIdx_q <= keyIdx_d;
      key_q    <= key_d;
      bad_q    <= bad_d;
    end
  end

  // Key byte 0 sits in the most significant byte of the key word.
  always_comb begin
    keyByte = 8'h00;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (keyIdx_q == KIW'(n)) keyByte = key_q[8*KEY_BYTES-1-8*n -: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    pt_d      = pt_q;
    keyIdx_d  = keyIdx_q;
    key_d     = key_q;
    bad_d     = bad_q;
    rdy       = 1'b0;
    pt_addr   = 8'h00;
    ct_addr   = 8'h00;
    ct_wrdata = 8'h00;
    ct_wren   = 1'b0;
    s_addr    = 8'h00;
    s_wrdata  = 8'h00;
    s_wren    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        rdy = 1'b1;
        if (en) begin
          key_d    = key;
          bad_d    = 1'b0;
          i_d      = 8'h00;
          j_d      = 8'h00;
          k_d      = 8'h00;
          keyIdx_d = '0;
          state_d  = INIT;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      INIT: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = KSA_RI;
      end

      KSA_RI: begin
        s_addr  = i_q;
        state_d = KSA_GI;
      end

      KSA_GI: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata + keyByte;
        s_addr  = j_d;
        state_d = KSA_GJ;
      end

      KSA_GJ: begin
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = KSA_WJ;
      end

      KSA_WJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        keyIdx_d = (keyIdx_q == KIW'(KEY_BYTES - 1)) ? '0 : keyIdx_q + 1'b1;
        state_d  = (i_q == 8'hFF) ? LEN_RD : KSA_RI;
      end

      LEN_RD: begin
        pt_addr = 8'h00;
        state_d = LEN_GET;
      end

      // The length byte is copied through in clear so the decryptor knows how much to read.
      LEN_GET: begin
        len_d     = pt_rddata;
        ct_addr   = 8'h00;
        ct_wrdata = pt_rddata;
        ct_wren   = 1'b1;
        i_d       = 8'h00;
        j_d       = 8'h00;
        k_d       = 8'd1;
        state_d   = (pt_rddata <= 8'd1) ? DONE : PRGA_RI;
      end

      PRGA_RI: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_d;
        pt_addr = k_q;
        state_d = PRGA_GI;
      end

      PRGA_GI: begin
        si_d    = s_rddata;
        pt_d    = pt_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_d;
        state_d = PRGA_GJ;
      end

      PRGA_GJ: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = PRGA_WJ;
      end

      PRGA_WJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = PRGA_RP;
      end

      // After the swap S[i]+S[j] is still si+sj, so the pad index needs no re-read.
      PRGA_RP: begin
        s_addr  = si_q + sj_q;
        state_d = PRGA_GP;
      end

      PRGA_GP: begin
        ct_addr   = k_q;
        ct_wrdata = s_rddata ^ pt_q;
        ct_wren   = 1'b1;
        if (pt_q < 8'h20 || pt_q > 8'h7E) bad_d = 1'b1;
        k_d       = k_q + 8'd1;
        state_d   = (k_q == len_q - 8'd1) ? DONE : PRGA_RI;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bad_pt = bad_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Self-checking bench for arc4_encrypt: RAM models around the DUT and a plain
// software ARC4 reference computed from the plaintext memory.
module tb_arc4_encrypt;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic        bad_pt;
  logic [7:0]  pt_addr, pt_rddata;
  logic [7:0]  ct_addr, ct_wrdata;
  logic        ct_wren;
  logic [7:0]  s_addr, s_rddata, s_wrdata;
  logic        s_wren;

  logic [7:0] ptMem [256];
  logic [7:0] ctMem [256];
  logic [7:0] sMem  [256];
  logic [7:0] expCt [256];
  logic [7:0] origPt[256];
  logic [7:0] vec1  [9];
  logic       expBad;

  int cycleCnt = 0;
  int lastCtCycle = 0;
  int ctWrites = 0;
  int ct255Writes = 0;
  int ct0Writes = 0;
  int bothWren = 0;
  int checks = 0;
  int errors = 0;

  arc4_encrypt #(.KEY_BYTES(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .bad_pt(bad_pt),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata),
    .ct_addr(ct_addr), .ct_wrdata(ct_wrdata), .ct_wren(ct_wren),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAMs with one-cycle read latency, plus write bookkeeping.
  always @(posedge clk) begin
    if (s_wren) sMem[s_addr] <= s_wrdata;
    s_rddata  <= sMem[s_addr];
    pt_rddata <= ptMem[pt_addr];
    cycleCnt  <= cycleCnt + 1;
    if (ct_wren) begin
      ctMem[ct_addr] <= ct_wrdata;
      ctWrites       <= ctWrites + 1;
      lastCtCycle    <= cycleCnt;
      if (ct_addr == 8'hFF) ct255Writes <= ct255Writes + 1;
      if (ct_addr == 8'h00) ct0Writes <= ct0Writes + 1;
    end
    if (ct_wren && s_wren) bothWren <= bothWren + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Textbook ARC4 over ptMem: byte 0 is the clear length, bytes 1..L-1 are encrypted.
  task automatic modelEncrypt(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    int i, j, len;
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + kb[n % 3]) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = ptMem[0];
    expCt[0] = ptMem[0];
    expBad = 1'b0;
    i = 0;
    j = 0;
    for (int n = 1; n < len; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      expCt[n] = ptMem[n] ^ s[(s[i] + s[j]) % 256];
      if (ptMem[n] < 8'h20 || ptMem[n] > 8'h7E) expBad = 1'b1;
    end
  endtask

  task automatic startRun(input logic [23:0] k);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(negedge clk);
    checkOutput("rdyDrop", {31'd0, rdy}, 0);
  endtask

  task automatic applyStimulus(input string name, input logic [23:0] k, input bit holdEn);
    int snapW, snap255, snap0, snapBoth, expWrites, len;
    bit seen;
    logic [7:0] lastIdx;
    len = ptMem[0];
    lastIdx = (len <= 1) ? 8'd0 : 8'(len - 1);
    expWrites = (len == 0) ? 1 : len;
    modelEncrypt(k);
    snapW = ctWrites; snap255 = ct255Writes; snap0 = ct0Writes; snapBoth = bothWren;
    startRun(k);
    if (!holdEn) en = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (holdEn && ct_wren && ct_addr == lastIdx) en = 1'b0;
      if (rdy) begin
        seen = 1'b1;
        break;
      end
    end
    en = 1'b0;
    checkOutput({name, ".done"}, {31'd0, seen}, 1);
    checkOutput({name, ".rdyTiming"}, cycleCnt, lastCtCycle + 1);
    checkOutput({name, ".ctCount"}, ctWrites - snapW, expWrites);
    checkOutput({name, ".ct255"}, ct255Writes - snap255, 0);
    checkOutput({name, ".starts"}, ct0Writes - snap0, 1);
    checkOutput({name, ".oneWren"}, bothWren - snapBoth, 0);
    checkOutput({name, ".badPt"}, {31'd0, bad_pt}, {31'd0, expBad});
    for (int n = 0; n < expWrites; n++)
      checkOutput($sformatf("%s.ct[%0d]", name, n), {24'd0, ctMem[n]}, {24'd0, expCt[n]});
  endtask

  task automatic loadText1();
    string txt;
    txt = "Plaintext";
    ptMem[0] = 8'h0A;
    for (int n = 0; n < 9; n++) ptMem[n+1] = txt.getc(n);
  endtask

  initial begin
    vec1 = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    for (int n = 0; n < 256; n++) begin
      ptMem[n] = 8'h00;
      sMem[n]  = 8'h00;
      ctMem[n] = 8'h00;
    end
    rst_n = 1'b0;
    en    = 1'b0;
    key   = 24'h0;
    repeat (3) @(negedge clk);
    checkOutput("rst.rdy", {31'd0, rdy}, 1);
    checkOutput("rst.bad", {31'd0, bad_pt}, 0);
    checkOutput("rst.wren", {30'd0, s_wren, ct_wren}, 0);
    checkOutput("rst.addr", {8'd0, s_addr, pt_addr, ct_addr}, 0);
    checkOutput("rst.data", {16'd0, s_wrdata, ct_wrdata}, 0);
    rst_n = 1'b1;

    loadText1();
    applyStimulus("t1", 24'h4B6579, 1'b0);
    for (int n = 0; n < 9; n++)
      checkOutput($sformatf("t1.vec[%0d]", n + 1), {24'd0, ctMem[n+1]}, {24'd0, vec1[n]});
    for (int n = 0; n < 10; n++) origPt[n] = ptMem[n];

    ptMem[0] = 8'h00;
    applyStimulus("t2", 24'h000018, 1'b0);

    ptMem[0] = 8'hFF;
    for (int n = 1; n < 256; n++) ptMem[n] = 8'($urandom_range(32, 126));
    applyStimulus("t3", 24'h1E4600, 1'b0);

    ptMem[0] = 8'h04; ptMem[1] = 8'h41; ptMem[2] = 8'h0D; ptMem[3] = 8'h42;
    applyStimulus("t4", 24'h000001, 1'b0);
    checkOutput("t4.badFixed", {31'd0, bad_pt}, 1);

    loadText1();
    startRun(24'h4B6579);
    en = 1'b0;
    repeat (400) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t5.rdy", {31'd0, rdy}, 1);
    checkOutput("t5.wren", {30'd0, s_wren, ct_wren}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("t5", 24'h4B6579, 1'b0);
    for (int n = 0; n < 9; n++)
      checkOutput($sformatf("t5.vec[%0d]", n + 1), {24'd0, ctMem[n+1]}, {24'd0, vec1[n]});

    // Feed the ciphertext back in: ARC4 is its own inverse under the same key.
    for (int n = 0; n < 10; n++) ptMem[n] = ctMem[n];
    applyStimulus("t6", 24'h4B6579, 1'b1);
    for (int n = 1; n < 10; n++)
      checkOutput($sformatf("t6.rt[%0d]", n), {24'd0, ctMem[n]}, {24'd0, origPt[n]});
    repeat (3) @(negedge clk);
    checkOutput("t6.idle", {31'd0, rdy}, 1);

    for (int r = 0; r < 6; r++) begin
      ptMem[0] = 8'($urandom_range(2, 40));
      for (int n = 1; n < 256; n++)
        ptMem[n] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(32, 126));
      applyStimulus($sformatf("rnd%0d", r), 24'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
